// File: rtl/rv32_fetch.sv
// rv32_fetch: sequential instruction fetch with credit-limited outstanding requests,
// an in-order response FIFO feeding execute, and redirect flush/discard handling.
module rv32_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        iw_valid,
    input  logic        iw_ready,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out
);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

    typedef enum logic {
        BOOT,
        FETCH
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem [FIFO_DEPTH];
    logic [31:0]   iw_mem [FIFO_DEPTH];

    logic [31:0]   redirect_base;
    logic [CW:0]   in_use;
    logic          req_fire;
    logic          rsp_to_disc;
    logic          rsp_to_out;
    logic          push;
    logic          pop;
    logic [CW-1:0] out_after;
    logic [CW-1:0] disc_after;
    logic          unused_redirect_bits;

    assign redirect_base        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Buffered words plus in-flight requests may never exceed the FIFO size.
    assign in_use         = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = (state_q == FETCH) && !redirect_valid && (in_use < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_to_disc = imem_rsp_valid && (discard_q != '0);
    assign rsp_to_out  = imem_rsp_valid && (discard_q == '0) && (outstanding_q != '0);
    assign push        = rsp_to_out && !redirect_valid;
    assign pop         = iw_valid && iw_ready;

    assign iw_valid = (count_q != '0);
    assign iw_out   = iw_valid ? iw_mem[rd_ptr_q] : NOP;
    assign pc_out   = iw_valid ? pc_mem[rd_ptr_q] : 32'h0000_0000;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            default: state_d = state_q;
        endcase

        out_after     = outstanding_q + CW'(req_fire) - CW'(rsp_to_out);
        disc_after    = discard_q - CW'(rsp_to_disc);
        fetch_pc_d    = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d      = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        outstanding_d = out_after;
        discard_d     = disc_after;
        count_d       = count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        // Everything still in flight becomes garbage to be dropped on arrival.
        if (redirect_valid) begin
            fetch_pc_d    = redirect_base;
            rsp_pc_d      = redirect_base;
            discard_d     = disc_after + out_after;
            outstanding_d = '0;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q] <= rsp_pc_q;
            iw_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    // A response nobody asked for means the memory broke the request/response contract.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(imem_rsp_valid && (outstanding_q == '0) && (discard_q == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_rv32_fetch.sv
// Directed testbench for rv32_fetch: cycle-exact vector table for streaming and
// backpressure, plus hand-written redirect, wrap-around and async-reset sequences.
`timescale 1ns/1ps
module tb_rv32_fetch;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] KEY       = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        iw_ready = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        iw_valid;
    logic [31:0] iw_out;
    logic [31:0] pc_out;

    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = 32'h0;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_iw_valid;
    logic [31:0] w_iw_out;
    logic [31:0] w_pc_out;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        iw_rdy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t       mq[$];
    vec_t        vecs[$];
    int          lat = 1;
    int          cyc = 0;
    logic        w_fire = 1'b0;
    logic [31:0] w_fire_addr = 32'h0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    rv32_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .iw_valid(iw_valid), .iw_ready(iw_ready),
        .iw_out(iw_out), .pc_out(pc_out)
    );

    rv32_fetch #(.RESET_PC(WRAP_BASE), .FIFO_DEPTH(2)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .iw_valid(w_iw_valid), .iw_ready(iw_ready),
        .iw_out(w_iw_out), .pc_out(w_pc_out)
    );

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] a,
                                input logic iv, input logic [31:0] pc);
        vec_t v;
        v.iw_rdy   = r;
        v.exp_rv   = rv;
        v.exp_addr = a;
        v.exp_iv   = iv;
        v.exp_pc   = pc;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Memory models drive responses for the upcoming edge, then outputs settle.
    task automatic apply_stimulus();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        w_rsp_valid = w_fire;
        w_rsp_data  = w_fire_addr ^ KEY;
        #1;
    endtask

    task automatic step_clock();
        if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
        if (imem_rsp_valid) mq.delete(0);
        w_fire      = w_req_valid && imem_req_ready;
        w_fire_addr = w_req_addr;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        w_rsp_valid    = 1'b0;
        w_fire         = 1'b0;
        mq.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cyc   = 1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs.push_back(mk(1'b1, 1'b0, 32'h00, 1'b0, 32'h00));
        vecs.push_back(mk(1'b1, 1'b1, 32'h00, 1'b0, 32'h00));
        vecs.push_back(mk(1'b1, 1'b1, 32'h04, 1'b0, 32'h00));
        vecs.push_back(mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h00));
        vecs.push_back(mk(1'b1, 1'b1, 32'h08, 1'b1, 32'h04));
        vecs.push_back(mk(1'b1, 1'b1, 32'h0C, 1'b0, 32'h00));
        vecs.push_back(mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h08));
        vecs.push_back(mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h0C));
        vecs.push_back(mk(1'b1, 1'b1, 32'h14, 1'b0, 32'h00));
        vecs.push_back(mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h10));
        vecs.push_back(mk(1'b1, 1'b1, 32'h18, 1'b1, 32'h14));
        vecs.push_back(mk(1'b0, 1'b1, 32'h1C, 1'b0, 32'h00));
        vecs.push_back(mk(1'b0, 1'b0, 32'h00, 1'b1, 32'h18));
        repeat (8) vecs.push_back(mk(1'b0, 1'b0, 32'h00, 1'b1, 32'h18));
        vecs.push_back(mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h18));
        vecs.push_back(mk(1'b1, 1'b1, 32'h20, 1'b1, 32'h1C));
        vecs.push_back(mk(1'b1, 1'b1, 32'h24, 1'b0, 32'h00));
        vecs.push_back(mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h20));
        vecs.push_back(mk(1'b1, 1'b1, 32'h28, 1'b1, 32'h24));

        imem_req_ready = 1'b1;
        lat = 1;
        @(negedge clk);
        apply_stimulus();
        check_bit("reset req_valid", imem_req_valid, 1'b0);
        check_bit("reset iw_valid", iw_valid, 1'b0);
        check_output("reset iw_out", iw_out, NOP);
        check_output("reset pc_out", pc_out, 32'h0);
        do_reset();

        // Streaming with 1-cycle memory, then a 10-cycle stall and release.
        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] wpc;
            iw_ready = vecs[i].iw_rdy;
            apply_stimulus();
            wpc = vecs[i].exp_pc + WRAP_BASE;
            check_bit($sformatf("row%0d req_valid", i + 1), imem_req_valid, vecs[i].exp_rv);
            check_bit($sformatf("row%0d iw_valid", i + 1), iw_valid, vecs[i].exp_iv);
            check_output($sformatf("row%0d pc_out", i + 1), pc_out, vecs[i].exp_pc);
            check_output($sformatf("row%0d iw_out", i + 1), iw_out,
                         vecs[i].exp_iv ? (vecs[i].exp_pc ^ KEY) : NOP);
            check_bit($sformatf("row%0d wrap req_valid", i + 1), w_req_valid, vecs[i].exp_rv);
            check_bit($sformatf("row%0d wrap iw_valid", i + 1), w_iw_valid, vecs[i].exp_iv);
            check_output($sformatf("row%0d wrap pc_out", i + 1), w_pc_out,
                         vecs[i].exp_iv ? wpc : 32'h0);
            check_output($sformatf("row%0d wrap iw_out", i + 1), w_iw_out,
                         vecs[i].exp_iv ? (wpc ^ KEY) : NOP);
            if (vecs[i].exp_rv) begin
                check_output($sformatf("row%0d req_addr", i + 1), imem_req_addr, vecs[i].exp_addr);
                check_output($sformatf("row%0d wrap req_addr", i + 1), w_req_addr,
                             vecs[i].exp_addr + WRAP_BASE);
            end
            step_clock();
        end

        // Redirect with two 3-cycle requests in flight: both late words dropped.
        lat = 3;
        do_reset();
        iw_ready = 1'b1;
        repeat (3) begin
            apply_stimulus();
            step_clock();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        apply_stimulus();
        check_bit("lat3 redirect req_valid", imem_req_valid, 1'b0);
        step_clock();
        redirect_valid = 1'b0;
        apply_stimulus();
        check_bit("lat3 s5 req_valid", imem_req_valid, 1'b1);
        check_output("lat3 s5 req_addr", imem_req_addr, 32'h100);
        check_bit("lat3 s5 iw_valid", iw_valid, 1'b0);
        step_clock();
        apply_stimulus();
        check_output("lat3 s6 req_addr", imem_req_addr, 32'h104);
        check_bit("lat3 s6 iw_valid", iw_valid, 1'b0);
        step_clock();
        apply_stimulus();
        check_bit("lat3 s7 iw_valid", iw_valid, 1'b0);
        step_clock();
        apply_stimulus();
        check_bit("lat3 s8 iw_valid", iw_valid, 1'b0);
        step_clock();
        apply_stimulus();
        check_bit("lat3 s9 iw_valid", iw_valid, 1'b1);
        check_output("lat3 s9 pc_out", pc_out, 32'h100);
        check_output("lat3 s9 iw_out", iw_out, 32'h100 ^ KEY);
        step_clock();
        apply_stimulus();
        check_output("lat3 s10 pc_out", pc_out, 32'h104);
        check_output("lat3 s10 req_addr", imem_req_addr, 32'h108);
        step_clock();

        // Redirect coinciding with an iw handshake and an arriving response.
        lat = 2;
        do_reset();
        iw_ready = 1'b1;
        repeat (4) begin
            apply_stimulus();
            step_clock();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        apply_stimulus();
        check_bit("coinc s5 iw_valid", iw_valid, 1'b1);
        check_output("coinc s5 pc_out", pc_out, 32'h0);
        check_bit("coinc s5 rsp_valid", imem_rsp_valid, 1'b1);
        step_clock();
        redirect_valid = 1'b0;
        apply_stimulus();
        check_bit("coinc s6 iw_valid", iw_valid, 1'b0);
        check_bit("coinc s6 req_valid", imem_req_valid, 1'b1);
        check_output("coinc s6 req_addr", imem_req_addr, 32'h40);
        step_clock();
        apply_stimulus();
        check_bit("coinc s7 iw_valid", iw_valid, 1'b0);
        check_output("coinc s7 req_addr", imem_req_addr, 32'h44);
        step_clock();
        apply_stimulus();
        check_bit("coinc s8 iw_valid", iw_valid, 1'b0);
        step_clock();
        apply_stimulus();
        check_bit("coinc s9 iw_valid", iw_valid, 1'b1);
        check_output("coinc s9 pc_out", pc_out, 32'h40);
        check_output("coinc s9 iw_out", iw_out, 32'h40 ^ KEY);
        step_clock();
        apply_stimulus();
        check_output("coinc s10 pc_out", pc_out, 32'h44);
        step_clock();

        // Back-to-back redirects during and right after BOOT; the last one wins.
        lat = 1;
        do_reset();
        iw_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        apply_stimulus();
        check_bit("boot s1 req_valid", imem_req_valid, 1'b0);
        step_clock();
        redirect_pc = 32'h0000_0301;
        apply_stimulus();
        check_bit("boot s2 req_valid", imem_req_valid, 1'b0);
        step_clock();
        redirect_valid = 1'b0;
        apply_stimulus();
        check_bit("boot s3 req_valid", imem_req_valid, 1'b1);
        check_output("boot s3 req_addr", imem_req_addr, 32'h300);
        step_clock();
        apply_stimulus();
        check_output("boot s4 req_addr", imem_req_addr, 32'h304);
        step_clock();
        iw_ready = 1'b0;
        apply_stimulus();
        check_output("boot s5 pc_out", pc_out, 32'h300);
        check_output("boot s5 iw_out", iw_out, 32'h300 ^ KEY);
        step_clock();

        // Asynchronous reset with two words buffered.
        apply_stimulus();
        check_bit("prerst iw_valid", iw_valid, 1'b1);
        check_bit("prerst req_valid", imem_req_valid, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_bit("async rst iw_valid", iw_valid, 1'b0);
        check_bit("async rst req_valid", imem_req_valid, 1'b0);
        check_output("async rst iw_out", iw_out, NOP);
        check_output("async rst pc_out", pc_out, 32'h0);
        do_reset();
        iw_ready = 1'b1;
        apply_stimulus();
        check_bit("restart s1 req_valid", imem_req_valid, 1'b0);
        step_clock();
        apply_stimulus();
        check_bit("restart s2 req_valid", imem_req_valid, 1'b1);
        check_output("restart s2 req_addr", imem_req_addr, 32'h0);
        step_clock();
        apply_stimulus();
        check_output("restart s3 req_addr", imem_req_addr, 32'h4);
        step_clock();
        apply_stimulus();
        check_output("restart s4 pc_out", pc_out, 32'h0);
        check_output("restart s4 iw_out", iw_out, 32'h0 ^ KEY);
        step_clock();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
